// File: rtl/jpeg_zigzag_quantizer.sv
// jpeg_zigzag_quantizer
// Takes 8x8 DCT coefficient blocks in raster order, one per cycle. Each
// coefficient is divided by its quantization table entry, rounding half away
// from zero, and the results leave in JPEG zigzag order. Two 64-entry banks
// form a ping-pong buffer, so one block can fill while the other drains.
//
// Optional feature macro: JPEG_ZQ_SAT_EN
//   defined     -> out-of-range results clamp to the signed WIDTH_OUT range and
//                  set the sticky sat_flag
//   not defined -> results wrap to the low WIDTH_OUT bits; sat_flag is tied 0
module jpeg_zigzag_quantizer #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int WIDTH_Q   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_Q*64-1:0]       quant_flat,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_IN-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic [5:0]                  out_index,
  output logic                        out_last,
  output logic                        sat_flag
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  // Zigzag index -> raster address within a block.
  localparam logic [5:0] ZZ_ROM [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Rounded quotient in WIDTH_IN+2 signed bits: the magnitude needs
  // WIDTH_IN+1 bits (|-2^(WIDTH_IN-1)| plus the rounding term) and one more
  // bit carries the sign back.
  function automatic logic signed [WIDTH_IN+1:0] quantize(
    input logic signed [WIDTH_IN-1:0] c,
    input logic [WIDTH_Q-1:0]         q
  );
    logic signed [WIDTH_IN:0]   c_ext;
    logic [WIDTH_IN:0]          q_eff;
    logic [WIDTH_IN:0]          mag;
    logic [WIDTH_IN:0]          quo;
    logic signed [WIDTH_IN+1:0] quo_s;
    c_ext = (WIDTH_IN+1)'(c);
    q_eff = (q == '0) ? (WIDTH_IN+1)'(1) : (WIDTH_IN+1)'(q);
    mag   = c_ext[WIDTH_IN] ? $unsigned(-c_ext) : $unsigned(c_ext);
    quo   = (mag + (q_eff >> 1)) / q_eff;
    quo_s = $signed({1'b0, quo});
    return c_ext[WIDTH_IN] ? -quo_s : quo_s;
  endfunction

`ifdef JPEG_ZQ_SAT_EN
  localparam logic signed [WIDTH_IN+1:0] OUT_MAX =
    {{(WIDTH_IN-WIDTH_OUT+3){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WIDTH_IN+1:0] OUT_MIN = ~OUT_MAX;

  function automatic logic out_of_range(input logic signed [WIDTH_IN+1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  function automatic logic signed [WIDTH_OUT-1:0] reduce(
    input logic signed [WIDTH_IN+1:0] v
  );
    if (v > OUT_MAX) return {1'b0, {(WIDTH_OUT-1){1'b1}}};
    if (v < OUT_MIN) return {1'b1, {(WIDTH_OUT-1){1'b0}}};
    return v[WIDTH_OUT-1:0];
  endfunction
`else
  function automatic logic signed [WIDTH_OUT-1:0] reduce(
    input logic signed [WIDTH_IN+1:0] v
  );
    return v[WIDTH_OUT-1:0];
  endfunction
`endif

  logic signed [WIDTH_IN-1:0] mem [128];
  bank_state_t                bank_st [2];

  logic                       wr_bank;
  logic [5:0]                 wr_cnt;
  logic                       wr_fire;

  rd_state_t                  rd_state;
  logic                       rd_bank;
  logic [5:0]                 rd_cnt;
  logic                       rd_done;
  logic [WIDTH_Q*64-1:0]      qtab;

  logic                       out_fire;
  logic                       blk_done;
  logic                       issue;
  logic                       enter_drain;

  logic [6:0]                 addr_p0;
  logic signed [WIDTH_IN-1:0] coef_p0;
  logic [WIDTH_Q-1:0]         q_p0;
  logic signed [WIDTH_IN+1:0] quo_p0;
  logic signed [WIDTH_OUT-1:0] res_p0;

  assign in_ready = (bank_st[wr_bank] != B_FULL);
  assign wr_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign blk_done = out_fire && out_last;

  // A new element enters the output register whenever it is empty or being
  // emptied on this edge; after all 64 have been issued the drain only waits
  // for the last beat to leave.
  assign issue = (rd_state == R_DRAIN) && !rd_done && (!out_valid || out_ready);

  assign enter_drain =
    ((rd_state == R_IDLE)  && (bank_st[rd_bank] == B_FULL)) ||
    ((rd_state == R_DRAIN) && blk_done && (bank_st[!rd_bank] == B_FULL));

  // Stage p0: zigzag lookup, buffer read and rounded divide.
  assign addr_p0 = {rd_bank, ZZ_ROM[rd_cnt]};
  assign coef_p0 = mem[addr_p0];
  assign q_p0    = qtab[rd_cnt*WIDTH_Q +: WIDTH_Q];
  assign quo_p0  = quantize(coef_p0, q_p0);
  assign res_p0  = reduce(quo_p0);

  // Buffer write: raster address inside the current write bank.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_cnt}] <= in_data;
  end

  // Write pointer: toggles bank after the 64th coefficient of a block.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= 6'd0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 6'd1;
      if (wr_cnt == 6'd63) wr_bank <= !wr_bank;
    end
  end

  // Bank occupancy: writer fills, last accepted output beat empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
    end else begin
      if (wr_fire) bank_st[wr_bank] <= (wr_cnt == 6'd63) ? B_FULL : B_FILLING;
      if (blk_done) bank_st[rd_bank] <= B_EMPTY;
    end
  end

  // Read FSM: waits for a full bank, then walks the 64 zigzag positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_bank  <= 1'b0;
      rd_cnt   <= 6'd0;
      rd_done  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (bank_st[rd_bank] == B_FULL) begin
            rd_state <= R_DRAIN;
            rd_cnt   <= 6'd0;
            rd_done  <= 1'b0;
          end
        end
        R_DRAIN: begin
          if (issue) begin
            rd_cnt <= rd_cnt + 6'd1;
            if (rd_cnt == 6'd63) rd_done <= 1'b1;
          end
          if (blk_done) begin
            rd_bank  <= !rd_bank;
            rd_cnt   <= 6'd0;
            rd_done  <= 1'b0;
            rd_state <= (bank_st[!rd_bank] == B_FULL) ? R_DRAIN : R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Table snapshot taken as each block starts draining.
  always_ff @(posedge clk) begin
    if (enter_drain) qtab <= quant_flat;
  end

  // Stage p1: output register, holds while stalled by out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= res_p0;
      out_index <= rd_cnt;
      out_last  <= (rd_cnt == 6'd63);
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef JPEG_ZQ_SAT_EN
  // Sticky saturation indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) sat_flag <= 1'b0;
    else if (issue && out_of_range(quo_p0)) sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_zigzag_quantizer.sv
// Testbench for jpeg_zigzag_quantizer: block-level reference model using
// diagonal-walk zigzag order and plain integer division.
module tb_jpeg_zigzag_quantizer;

  localparam int WI = 32;
  localparam int WO = 16;
  localparam int WQ = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [WQ*64-1:0]     quant_flat = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [WI-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [WO-1:0] out_data;
  logic [5:0]           out_index;
  logic                 out_last;
  logic                 sat_flag;

  jpeg_zigzag_quantizer #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .WIDTH_Q(WQ)) dut (
    .clk(clk), .rst(rst), .quant_flat(quant_flat),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  zz [64];
  int  stim [3][64];
  int  qt [4][64];
  bit  sat_exp = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Zigzag: walk anti-diagonals, alternating direction.
  task automatic build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0)
        for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
      else
        for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
    end
  endtask

  function automatic longint model_q(longint c, longint q);
    longint qe = (q == 0) ? 1 : q;
    longint a  = (c < 0) ? -c : c;
    longint m  = (a + qe / 2) / qe;
    return (c < 0) ? -m : m;
  endfunction

  function automatic bit model_ovf(longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic longint model_reduce(longint v);
`ifdef JPEG_ZQ_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [WO-1:0] t;
    t = WO'(v);
    return longint'(t);
`endif
  endfunction

  task automatic set_table(input int b);
    for (int k = 0; k < 64; k++) quant_flat[k*WQ +: WQ] = WQ'(qt[b][k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sat_exp = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_in_ready"}, in_ready, 1);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_data"}, out_data, 0);
    check({pfx, "_out_index"}, out_index, 0);
    check({pfx, "_out_last"}, out_last, 0);
    check({pfx, "_sat_flag"}, sat_flag, 0);
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready held low until the input
  // side stalls, then toggling every cycle.
  task automatic run_blocks(input string tag, input int nblk, input int rmode,
                            input bit gaps, input bit chg, input bit lat);
    int in_n = 0, out_n = 0, cyc = 0, acc_cyc = 0;
    bit hold = (rmode == 2);
    bit lat_done = !lat;
    set_table(0);
    while (out_n < nblk * 64 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = hold ? 1'b0 : cyc[0];
      endcase
      if (!lat_done && out_valid) begin
        check({tag, "_latency"}, cyc - acc_cyc, 3);
        lat_done = 1'b1;
      end
      if (out_valid && out_ready) begin
        int b = out_n / 64;
        int k = out_n % 64;
        longint raw = model_q(stim[b][zz[k]], qt[chg ? b : 0][k]);
`ifdef JPEG_ZQ_SAT_EN
        if (model_ovf(raw)) sat_exp = 1'b1;
`endif
        check({tag, "_data"}, out_data, model_reduce(raw));
        check({tag, "_index"}, out_index, k);
        check({tag, "_last"}, out_last, (k == 63));
        if (chg && k == 20 && b < 3) set_table(b + 1);
        out_n++;
      end
      if (in_n < nblk * 64) begin
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = stim[in_n / 64][in_n % 64];
        if (hold && !in_ready) begin
          check({tag, "_bp_accepts"}, in_n, 128);
          hold = 1'b0;
        end
        if (in_valid && in_ready) begin
          if (in_n == 63) acc_cyc = cyc;
          in_n++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    check({tag, "_out_count"}, out_n, nblk * 64);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check({tag, "_sat_flag"}, sat_flag, sat_exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    build_zz();
    do_reset();
    check_reset_vals("reset");

    // zigzag order: value = raster index, unit table
    for (int i = 0; i < 64; i++) begin stim[0][i] = i; qt[0][i] = 1; end
    run_blocks("zigzag", 1, 0, 0, 0, 0);

    // uniform 50 / 5 with latency check
    for (int i = 0; i < 64; i++) begin stim[0][i] = 50; qt[0][i] = 5; end
    run_blocks("uniform", 1, 0, 0, 0, 1);

    // rounding and Q==0 handling
    for (int i = 0; i < 64; i++) begin stim[0][i] = 0; qt[0][i] = 1 + (i % 7); end
    stim[0][0] = 7;  qt[0][0] = 2;
    stim[0][1] = -7; qt[0][1] = 2;
    stim[0][8] = 5;  qt[0][2] = 3;
    stim[0][16] = 9; qt[0][3] = 0;
    run_blocks("round", 1, 0, 0, 0, 0);

    // random coefficients and tables, random handshakes
    for (int i = 0; i < 64; i++)
      qt[0][i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 40));
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++) begin
        int r = $urandom;
        stim[b][i] = r >>> $urandom_range(0, 28);
      end
    run_blocks("random", 2, 1, 1, 0, 0);

    // backpressure, three blocks, table swapped mid-drain
    do_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 64; i++) qt[b][i] = $urandom_range(1, 64);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 64; i++) stim[b][i] = int'($urandom_range(0, 20000)) - 10000;
    run_blocks("backpressure", 3, 2, 0, 1, 0);

    // saturation / wrap
    do_reset();
    for (int i = 0; i < 64; i++) begin stim[0][i] = i * 3; qt[0][i] = 1; end
    stim[0][0]  = 100000;
    stim[0][9]  = -100000;
    stim[0][63] = 40000;
    run_blocks("sat", 1, 0, 0, 0, 0);

    // reset in the middle of a block
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 1000 + i;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sat_exp = 1'b0;
    check_reset_vals("midreset");
    for (int i = 0; i < 64; i++) begin stim[0][i] = i; qt[0][i] = 1; end
    run_blocks("post_reset", 1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_zigzag_quantizer.md
# jpeg_zigzag_quantizer

Encoder-side counterpart of the JPEG dequant/inverse-zigzag stage. Accepts 8x8 DCT coefficient blocks streamed in raster order, one per cycle. Quantizes each coefficient by the matching entry of a 64-entry quantization table and emits the results in zigzag order for the entropy coder. A two-bank ping-pong buffer sustains one coefficient per cycle in and out.

## Interface
- `WIDTH_IN`, 32: signed DCT coefficient width, input side.
- `WIDTH_OUT`, 16: signed quantized coefficient width, output side.
- `WIDTH_Q`, 16: unsigned quantization table entry width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `quant_flat` in `WIDTH_Q*64`: quant table in zigzag order; entry k at bits `[k*WIDTH_Q +: WIDTH_Q]`.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a coefficient.
- `in_data` in `WIDTH_IN`, signed: coefficient. Raster order; the n-th accepted beat of a block is row n/8, column n%8.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out `WIDTH_OUT`, signed: quantized coefficient.
- `out_index` out 6: zigzag index (0..63) of `out_data`.
- `out_last` out 1: high with `out_index`==63.
- `sat_flag` out 1: sticky; set when any output saturated (see Configuration).

## Operation
- Handshakes: a beat transfers when valid && ready on a rising edge.
  - Valid must not depend combinationally on ready.
  - Once `out_valid` is asserted, `out_data`, `out_index` and `out_last` hold until accepted.
- Two banks of 64 x `WIDTH_IN`. Each bank is EMPTY, FILLING or FULL.
- Write side:
  - `wr_bank` and `wr_cnt` (0..63) address the current bank at raster address `wr_cnt`.
  - `in_ready` = current write bank is not FULL.
  - On accept of `wr_cnt`==63: the bank becomes FULL, `wr_bank` toggles and `wr_cnt` returns to 0.
- Read-side FSM:
  - R_IDLE -> R_DRAIN when the bank at `rd_bank` is FULL. On that transition `quant_flat` is latched into an internal table register; changes to `quant_flat` mid-block do not affect that block.
  - In R_DRAIN, `rd_cnt` (zigzag index 0..63) maps through the zigzag ROM to a raster address. Standard JPEG order: 0,1,8,16,9,2,3,10,17,24,...,63.
  - When output beat 63 is accepted: the bank becomes EMPTY, `rd_bank` toggles, and the FSM goes to R_IDLE. If the other bank is already FULL, it goes directly to R_DRAIN (no bubble).
- Arithmetic per output, with c = coefficient and Q = latched entry:
  - Q==0 is treated as Q=1.
  - Magnitude m = (|c| + floor(Q/2)) / Q, integer floor. This rounds half away from zero.
  - Result = -m if c<0, else m.
  - The intermediate width is `WIDTH_IN`+1 so no overflow occurs before the divide.
  - The result is reduced to `WIDTH_OUT` per Configuration.
- Simultaneous events:
  - A write into one bank and a drain of the other in the same cycle is legal.
  - A bank freed on the same edge the writer needs it: `in_ready` rises the following cycle.
- Reset, including mid-block, produces the reset values below:
  - Both banks EMPTY; `wr_bank`, `wr_cnt`, `rd_bank`, `rd_cnt` = 0; FSM in R_IDLE.
  - Partial blocks are discarded; buffer contents need not be cleared.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `sat_flag`=0.
- Latency: 64th input of a block accepted at edge N -> first output (`out_index`=0) valid after edge N+2.
  - Edge N+1: FSM enters R_DRAIN and latches the table.
  - Edge N+2: registered read, divide and output stage.
- Throughput: one output per cycle while `out_ready`=1. One input per cycle while a bank is free.
- Backpressure: with `out_ready` held 0, at most 128 inputs are accepted, then `in_ready`=0.
- The output register stalls in place when `out_valid` && !`out_ready`, and the read pointer does not advance.

## Configuration
- `JPEG_ZQ_SAT_EN`, defined: results outside the `WIDTH_OUT` signed range clamp to +/-(2^(`WIDTH_OUT`-1)) (max positive 2^(`WIDTH_OUT`-1)-1). `sat_flag` sets on the cycle such an output is produced and clears only on `rst`.
- Not defined: results are truncated to the low `WIDTH_OUT` bits (two's-complement wrap). `sat_flag` is tied 0.

## Test plan
- Zigzag order: input value = raster index 0..63, all Q=1, `out_ready`=1.
  - Expect `out_data` 0,1,8,16,9,2,3,10,17,24,... ending 63.
  - Expect `out_index` 0..63, and `out_last` only on the 64th output.
- Uniform quant: all inputs 50, all Q=5.
  - Expect 64 outputs of 10.
  - Expect first output exactly 2 cycles after the last input accept.
- Rounding and edges:
  - raster 0 = 7 with Q[0]=2 -> 4;
  - raster 1 = -7 with Q[1]=2 -> -4;
  - raster 8 = 5 with Q[2]=3 -> 2;
  - raster 16 = 9 with Q[3]=0 -> 9;
  - all other inputs 0 -> 0.
- Backpressure: three blocks streamed back-to-back with `out_ready` toggling every cycle.
  - `in_ready` falls after 128 accepts.
  - All 192 outputs are correct and in order, with no duplicates.
  - A `quant_flat` change mid-drain affects only the next block.
- Saturation: input 100000 with Q=1, `WIDTH_OUT`=16.
  - With `JPEG_ZQ_SAT_EN`: output 32767 and `sat_flag`=1.
  - Without: output -31072 and `sat_flag`=0.
- Reset mid-block: assert `rst` for one cycle after 30 inputs of block 1.
  - Expect `out_valid`=0 and `in_ready`=1.
  - The next 64 inputs form a clean block whose outputs match the zigzag-order expectation.
